// File: rtl/fp32_add_sequencer.sv
// fp32_add_sequencer: tagged command FIFO plus issue FSM in front of a
// multi-cycle fp32 adder (rd/wr handshake) with a valid/ready result port.
module fp32_add_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [31:0]      cmd_x,
    input  logic [31:0]      cmd_y,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             add_rd,
    output logic             add_op,
    output logic [31:0]      add_x,
    output logic [31:0]      add_y,
    input  logic             add_wr,
    input  logic [31:0]      add_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_z,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_nan,
    output logic             res_inf,
    output logic             res_zero,
    output logic             res_timeout,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP
    } state_t;

    state_t state, state_nx;

    logic [31:0]      mem_x   [DEPTH];
    logic [31:0]      mem_y   [DEPTH];
    logic             mem_op  [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    tcnt;
    logic          push, pop, full, empty, to_hit;
    logic          load, cap_ok, cap_to;
    logic          z_nan, z_inf, z_zero;

    assign full      = count == (AW+1)'(DEPTH);
    assign empty     = count == '0;
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = cap_ok || cap_to;
    assign to_hit    = tcnt == 8'(TIMEOUT - 1);

    assign z_nan  = (&add_z[30:23]) && (|add_z[22:0]);
    assign z_inf  = (&add_z[30:23]) && !(|add_z[22:0]);
    assign z_zero = !(|add_z[30:23]) && !(|add_z[22:0]);

    // Storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr]   <= cmd_x;
            mem_y[wr_ptr]   <= cmd_y;
            mem_op[wr_ptr]  <= cmd_op;
            mem_tag[wr_ptr] <= cmd_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (!empty && !res_valid) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (add_wr || to_hit) state_nx = GAP;
            GAP:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        add_rd = 1'b0;
        load   = 1'b0;
        cap_ok = 1'b0;
        cap_to = 1'b0;
        busy   = !empty || (state != IDLE);
        unique case (state)
            IDLE:  load = !empty && !res_valid;
            ISSUE: add_rd = 1'b1;
            WAIT: begin
                cap_ok = add_wr;
                cap_to = !add_wr && to_hit;
            end
            default: ;
        endcase
    end

    // Operands are loaded on the way into ISSUE so they are valid with add_rd.
    always_ff @(posedge clk) begin
        if (reset) begin
            add_op <= 1'b0;
            add_x  <= '0;
            add_y  <= '0;
            tcnt   <= '0;
        end else begin
            if (load) begin
                add_op <= mem_op[rd_ptr];
                add_x  <= mem_x[rd_ptr];
                add_y  <= mem_y[rd_ptr];
            end
            if (state == ISSUE)     tcnt <= '0;
            else if (state == WAIT) tcnt <= tcnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid   <= 1'b0;
            res_z       <= '0;
            res_tag     <= '0;
            res_nan     <= 1'b0;
            res_inf     <= 1'b0;
            res_zero    <= 1'b0;
            res_timeout <= 1'b0;
        end else if (cap_ok) begin
            res_valid   <= 1'b1;
            res_z       <= add_z;
            res_tag     <= mem_tag[rd_ptr];
            res_nan     <= z_nan;
            res_inf     <= z_inf;
            res_zero    <= z_zero;
            res_timeout <= 1'b0;
        end else if (cap_to) begin
            res_valid   <= 1'b1;
            res_z       <= 32'h7FFF_FFFF;
            res_tag     <= mem_tag[rd_ptr];
            res_nan     <= 1'b1;
            res_inf     <= 1'b0;
            res_zero    <= 1'b0;
            res_timeout <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp32_add_sequencer.sv
// Directed bench for fp32_add_sequencer with a behavioural adder that
// answers from a preloaded queue after a fixed latency.
module tb_fp32_add_sequencer;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [31:0]      cmd_x;
    logic [31:0]      cmd_y;
    logic [TAG_W-1:0] cmd_tag;
    logic             add_rd;
    logic             add_op;
    logic [31:0]      add_x;
    logic [31:0]      add_y;
    logic             add_wr;
    logic [31:0]      add_z;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_z;
    logic [TAG_W-1:0] res_tag;
    logic             res_nan;
    logic             res_inf;
    logic             res_zero;
    logic             res_timeout;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int rd_count = 0;
    bit withhold = 1'b0;
    logic [31:0] ans_q[$];

    fp32_add_sequencer #(
        .DEPTH(DEPTH),
        .TAG_W(TAG_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_x(cmd_x),
        .cmd_y(cmd_y),
        .cmd_tag(cmd_tag),
        .add_rd(add_rd),
        .add_op(add_op),
        .add_x(add_x),
        .add_y(add_y),
        .add_wr(add_wr),
        .add_z(add_z),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_z(res_z),
        .res_tag(res_tag),
        .res_nan(res_nan),
        .res_inf(res_inf),
        .res_zero(res_zero),
        .res_timeout(res_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (add_rd === 1'b1) rd_count++;

    // Adder model: answers after LAT cycles, checks operand stability.
    initial begin
        logic [31:0] cx, cy, z;
        logic        cop;
        forever begin
            @(negedge clk);
            if (add_rd === 1'b1 && !withhold && !reset) begin
                cx = add_x;
                cy = add_y;
                cop = add_op;
                chk("adder_answer_avail", 32'(ans_q.size() > 0), 32'd1);
                z = (ans_q.size() > 0) ? ans_q.pop_front() : 32'h0;
                repeat (LAT) begin
                    @(negedge clk);
                    chk("stable_x", add_x, cx);
                    chk("stable_y", add_y, cy);
                    chk("stable_op", 32'(add_op), 32'(cop));
                end
                add_wr = 1'b1;
                add_z = z;
                @(negedge clk);
                add_wr = 1'b0;
                add_z = '0;
            end
        end
    end

    task automatic push(input logic op, input logic [31:0] x,
                        input logic [31:0] y, input logic [TAG_W-1:0] tag);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_x = x;
        cmd_y = y;
        cmd_tag = tag;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("push_accepted", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_result(input string name, input logic [31:0] z,
                              input logic [TAG_W-1:0] tag, input logic nan,
                              input logic inf, input logic zero,
                              input logic to);
        int n = 0;
        while (!res_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, 32'(res_valid), 32'd1);
        chk({name, "_z"}, res_z, z);
        chk({name, "_tag"}, 32'(res_tag), 32'(tag));
        chk({name, "_flags"}, {28'd0, res_nan, res_inf, res_zero, res_timeout},
            {28'd0, nan, inf, zero, to});
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({name, "_taken"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        int n;
        int r0;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 1'b0;
        cmd_x = '0;
        cmd_y = '0;
        cmd_tag = '0;
        add_wr = 1'b1;
        add_z = 32'hDEAD_BEEF;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        add_wr = 1'b0;
        add_z = '0;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_add_rd", 32'(add_rd), 32'd0);
        chk("rst_add_x", add_x, 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_z", res_z, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1.0 + 2.0 = 3.0
        ans_q.push_back(32'h4040_0000);
        push(1'b0, 32'h3F80_0000, 32'h4000_0000, 4'd5);
        get_result("add_1p2", 32'h4040_0000, 4'd5, 0, 0, 0, 0);
        chk("t1_rd_pulses", rd_count, 1);
        repeat (3) @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Fill the FIFO; the first pop is still LAT cycles away.
        for (int i = 0; i < DEPTH; i++) begin
            ans_q.push_back(32'h4100_0000 + 32'(i));
            push(1'(i), 32'h3F80_0000 + 32'(i), 32'h4000_0000, 4'(8 + i));
        end
        chk("t2_full_ready", 32'(cmd_ready), 32'd0);
        ans_q.push_back(32'h4100_0000 + 32'(DEPTH));
        push(1'b0, 32'h3F80_0000, 32'h4000_0000, 4'(8 + DEPTH));
        for (int i = 0; i <= DEPTH; i++)
            get_result("order", 32'h4100_0000 + 32'(i), 4'(8 + i), 0, 0, 0, 0);
        chk("t2_rd_pulses", rd_count, 1 + DEPTH + 1);

        // inf - inf, 1 - 1, and an overflow to inf
        ans_q.push_back(32'h7FFF_FFFF);
        push(1'b1, 32'h7F80_0000, 32'h7F80_0000, 4'd1);
        get_result("inf_sub", 32'h7FFF_FFFF, 4'd1, 1, 0, 0, 0);
        ans_q.push_back(32'h0000_0000);
        push(1'b1, 32'h3F80_0000, 32'h3F80_0000, 4'd2);
        get_result("one_sub", 32'h0000_0000, 4'd2, 0, 0, 1, 0);
        ans_q.push_back(32'h7F80_0000);
        push(1'b0, 32'h7F00_0000, 32'h7F00_0000, 4'd3);
        get_result("ovf_add", 32'h7F80_0000, 4'd3, 0, 1, 0, 0);

        // Timeout: add_rd seen in cycle k, counter hits TIMEOUT-1 in
        // cycle k+TIMEOUT, so res_valid is visible in cycle k+TIMEOUT+1.
        withhold = 1'b1;
        push(1'b0, 32'h3F80_0000, 32'h3F80_0000, 4'd9);
        n = 0;
        while (!add_rd && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_issue_seen", 32'(add_rd), 32'd1);
        n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", n, TIMEOUT + 1);
        withhold = 1'b0;
        add_wr = 1'b1;
        add_z = 32'h1234_5678;
        @(negedge clk);
        add_wr = 1'b0;
        add_z = '0;
        chk("to_stray_held_z", res_z, 32'h7FFF_FFFF);
        get_result("timeout", 32'h7FFF_FFFF, 4'd9, 1, 0, 0, 1);
        add_wr = 1'b1;
        add_z = 32'h1234_5678;
        @(negedge clk);
        add_wr = 1'b0;
        add_z = '0;
        repeat (3) @(negedge clk);
        chk("to_stray_no_res", 32'(res_valid), 32'd0);
        ans_q.push_back(32'h4080_0000);
        push(1'b0, 32'h4000_0000, 32'h4000_0000, 4'd3);
        get_result("after_to", 32'h4080_0000, 4'd3, 0, 0, 0, 0);

        // Back-pressure: second op must wait for the first result to drain.
        r0 = rd_count;
        ans_q.push_back(32'h4040_0000);
        ans_q.push_back(32'hC000_0000);
        push(1'b0, 32'h3F80_0000, 32'h4000_0000, 4'd1);
        push(1'b1, 32'hBF80_0000, 32'h3F80_0000, 4'd2);
        repeat (20) @(negedge clk);
        chk("bp_one_issue", rd_count, r0 + 1);
        chk("bp_res_held", 32'(res_valid), 32'd1);
        get_result("bp_first", 32'h4040_0000, 4'd1, 0, 0, 0, 0);
        get_result("bp_second", 32'hC000_0000, 4'd2, 0, 0, 0, 0);
        chk("bp_two_issues", rd_count, r0 + 2);

        // Reset while waiting on the adder.
        withhold = 1'b1;
        push(1'b1, 32'h4000_0000, 32'h3F80_0000, 4'd6);
        push(1'b0, 32'h4000_0000, 32'h3F80_0000, 4'd7);
        n = 0;
        while (!add_rd && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("rw_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rw_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rw_add_rd", 32'(add_rd), 32'd0);
        chk("rw_add_x", add_x, 32'd0);
        chk("rw_add_y", add_y, 32'd0);
        chk("rw_add_op", 32'(add_op), 32'd0);
        chk("rw_res_valid", 32'(res_valid), 32'd0);
        chk("rw_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        r0 = rd_count;
        repeat (100) @(negedge clk);
        chk("rw_no_issue", rd_count, r0);
        chk("rw_no_result", 32'(res_valid), 32'd0);
        chk("rw_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
